kbd_ps2_fifo: RTL

Parametrised PS/2 keyboard front end for the terminal: receives PS/2 frames with full start/parity/stop checking and a stall timeout, tracks shift, ctrl and caps-lock state, translates make codes to ASCII, and expands the arrow keys to VT52 escape sequences. Translated bytes are buffered in an internal FIFO and presented on a valid/ready port to the terminal core.

---
 rtl/kbd_pkg.sv | 111 +++++++++++
 rtl/ps2_rx.sv | 100 ++++++++++
 rtl/kbd_ps2_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared scan-code / ASCII constants and the US-layout make-code translator
// used by the PS/2 keyboard front end.
package kbd_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_RIGHT  = 8'h74;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_TAB    = 8'h0D;
   localparam logic [7:0] SC_ESC    = 8'h76;
   localparam logic [7:0] SC_SPACE  = 8'h29;

   localparam logic [7:0] ASC_ESC = 8'h1B;
   localparam logic [7:0] ASC_CR  = 8'h0D;
   localparam logic [7:0] ASC_BS  = 8'h08;
   localparam logic [7:0] ASC_TAB = 8'h09;

   typedef enum logic {RX_IDLE, RX_BITS} rx_state_e;

   typedef struct packed {
      logic       hit;
      logic [7:0] ch;
   } xlat_t;

   typedef struct packed {
      logic       vld;
      logic       esc;
      logic [7:0] ch;
   } seq_req_t;

   function automatic xlat_t scan_to_ascii(input logic [7:0] code, input logic shift,
                                           input logic caps, input logic ctrl);
      xlat_t      r;
      logic [7:0] lc, un, sh;
      r  = '0;
      lc = 8'h00;
      un = 8'h00;
      sh = 8'h00;
      case (code)
         8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
         8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
         8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
         8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
         8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
         8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
         8'h35: lc = "y";  8'h1A: lc = "z";
         default: lc = 8'h00;
      endcase
      case (code)
         8'h16: begin un = "1"; sh = "!"; end
         8'h1E: begin un = "2"; sh = "@"; end
         8'h26: begin un = "3"; sh = "#"; end
         8'h25: begin un = "4"; sh = "$"; end
         8'h2E: begin un = "5"; sh = "%"; end
         8'h36: begin un = "6"; sh = "^"; end
         8'h3D: begin un = "7"; sh = "&"; end
         8'h3E: begin un = "8"; sh = "*"; end
         8'h46: begin un = "9"; sh = "("; end
         8'h45: begin un = "0"; sh = ")"; end
         8'h0E: begin un = 8'h60; sh = "~"; end
         8'h4E: begin un = "-"; sh = "_"; end
         8'h55: begin un = "="; sh = "+"; end
         8'h54: begin un = "["; sh = "{"; end
         8'h5B: begin un = "]"; sh = "}"; end
         8'h5D: begin un = 8'h5C; sh = "|"; end
         8'h4C: begin un = ";"; sh = ":"; end
         8'h52: begin un = 8'h27; sh = 8'h22; end
         8'h41: begin un = ","; sh = "<"; end
         8'h49: begin un = "."; sh = ">"; end
         8'h4A: begin un = "/"; sh = "?"; end
         SC_SPACE: begin un = 8'h20;   sh = 8'h20;   end
         SC_ENTER: begin un = ASC_CR;  sh = ASC_CR;  end
         SC_BKSP:  begin un = ASC_BS;  sh = ASC_BS;  end
         SC_TAB:   begin un = ASC_TAB; sh = ASC_TAB; end
         SC_ESC:   begin un = ASC_ESC; sh = ASC_ESC; end
         default:  begin un = 8'h00;   sh = 8'h00;   end
      endcase
      if (lc != 8'h00) begin
         r.hit = 1'b1;
         if (ctrl) r.ch = (lc - 8'h20) & 8'h1F;
         else      r.ch = (shift ^ caps) ? (lc - 8'h20) : lc;
      end else if (un != 8'h00) begin
         r.hit = 1'b1;
         r.ch  = shift ? sh : un;
      end
      return r;
   endfunction

   // Arrow keys become ESC + this letter (VT52 cursor keys).
   function automatic xlat_t ext_to_vt52(input logic [7:0] code);
      xlat_t r;
      r = '0;
      case (code)
         SC_UP:    r = '{hit: 1'b1, ch: "A"};
         SC_DOWN:  r = '{hit: 1'b1, ch: "B"};
         SC_RIGHT: r = '{hit: 1'b1, ch: "C"};
         SC_LEFT:  r = '{hit: 1'b1, ch: "D"};
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, shifts 11 bits LSB first on
// each falling ps2_clk edge, checks start/parity/stop and aborts stalled frames.
module ps2_rx
   import kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       byte_stb_o,
   output logic [7:0] byte_o,
   output logic       err_stb_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sclk_q, sdat_q;
   logic                   prev_q;
   rx_state_e              state_q;
   logic [3:0]             cnt_q;
   logic [9:0]             sh_q;
   logic [TW-1:0]          tmo_q;
   logic                   stb_q, err_q;
   logic [7:0]             byte_q;

   logic        clk_s, dat_s, fall, frame_ok;
   logic [10:0] frame_d;

   assign clk_s    = sclk_q[SYNC_STAGES-1];
   assign dat_s    = sdat_q[SYNC_STAGES-1];
   assign fall     = prev_q & ~clk_s;
   assign frame_d  = {dat_s, sh_q};
   assign frame_ok = ~frame_d[0] & (^frame_d[9:1]) & frame_d[10];

   // Sync flops reset to the idle-high line level so clr never fakes an edge.
   always_ff @(posedge clk) begin
      if (clr) begin
         sclk_q  <= '1;
         sdat_q  <= '1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= 4'd0;
         sh_q    <= '0;
         tmo_q   <= '0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
         byte_q  <= 8'h00;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], ps2_clk_i};
         sdat_q <= {sdat_q[SYNC_STAGES-2:0], ps2_data_i};
         prev_q <= clk_s;
         stb_q  <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (fall) begin
                  sh_q    <= frame_d[10:1];
                  cnt_q   <= 4'd1;
                  tmo_q   <= '0;
                  state_q <= RX_BITS;
               end
            end
            RX_BITS: begin
               if (fall) begin
                  sh_q  <= frame_d[10:1];
                  tmo_q <= '0;
                  if (cnt_q == 4'd10) begin
                     state_q <= RX_IDLE;
                     cnt_q   <= 4'd0;
                     if (frame_ok) begin
                        stb_q  <= 1'b1;
                        byte_q <= frame_d[8:1];
                     end else begin
                        err_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  state_q <= RX_IDLE;
                  cnt_q   <= 4'd0;
                  err_q   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign byte_stb_o = stb_q;
   assign byte_o     = byte_q;
   assign err_stb_o  = err_q;

endmodule

// File: rtl/kbd_ps2_fifo.sv
// PS/2 keyboard front end: prefix/modifier tracking, ASCII / VT52 translation
// and an output FIFO on a valid/ready port.
module kbd_ps2_fifo
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 2;

   logic       rx_stb, rx_err;
   logic [7:0] rx_byte;

   ps2_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) u_rx (
      .clk       (clk),
      .clr       (clr),
      .ps2_clk_i (ps2_clk),
      .ps2_data_i(ps2_data),
      .byte_stb_o(rx_stb),
      .byte_o    (rx_byte),
      .err_stb_o (rx_err)
   );

   // Stage 1: prefixes and modifiers; non-modifier makes become events.
   logic       ext_q, brk_q;
   logic       lshift_q, rshift_q, lctrl_q, rctrl_q, caps_on_q, caps_held_q;
   logic       ev_vld_q, ev_ext_q, ev_shift_q, ev_caps_q, ev_ctrl_q;
   logic [7:0] ev_code_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         lctrl_q     <= 1'b0;
         rctrl_q     <= 1'b0;
         caps_on_q   <= 1'b0;
         caps_held_q <= 1'b0;
         ev_vld_q    <= 1'b0;
         ev_ext_q    <= 1'b0;
         ev_shift_q  <= 1'b0;
         ev_caps_q   <= 1'b0;
         ev_ctrl_q   <= 1'b0;
         ev_code_q   <= 8'h00;
      end else begin
         ev_vld_q <= 1'b0;
         if (rx_err) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (rx_stb) begin
            if (rx_byte == SC_EXT) begin
               ext_q <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
               brk_q <= 1'b1;
            end else begin
               ext_q <= 1'b0;
               brk_q <= 1'b0;
               if (!ext_q && rx_byte == SC_LSHIFT) begin
                  lshift_q <= ~brk_q;
               end else if (!ext_q && rx_byte == SC_RSHIFT) begin
                  rshift_q <= ~brk_q;
               end else if (rx_byte == SC_CTRL) begin
                  if (ext_q) rctrl_q <= ~brk_q;
                  else       lctrl_q <= ~brk_q;
               end else if (!ext_q && rx_byte == SC_CAPS) begin
                  // caps_held suppresses re-toggling on typematic repeats
                  if (brk_q) begin
                     caps_held_q <= 1'b0;
                  end else begin
                     if (!caps_held_q) caps_on_q <= ~caps_on_q;
                     caps_held_q <= 1'b1;
                  end
               end else if (!brk_q) begin
                  ev_vld_q   <= 1'b1;
                  ev_code_q  <= rx_byte;
                  ev_ext_q   <= ext_q;
                  ev_shift_q <= lshift_q | rshift_q;
                  ev_caps_q  <= caps_on_q;
                  ev_ctrl_q  <= lctrl_q | rctrl_q;
               end
            end
         end
      end
   end

   // Stage 2: translate the event into a one- or two-byte request.
   xlat_t    xl, xa;
   seq_req_t req_d, req_q;

   always_comb begin
      xl    = scan_to_ascii(ev_code_q, ev_shift_q, ev_caps_q, ev_ctrl_q);
      xa    = ext_to_vt52(ev_code_q);
      req_d = '0;
      if (ev_vld_q) begin
         req_d.vld = ev_ext_q ? xa.hit : xl.hit;
         req_d.esc = ev_ext_q;
         req_d.ch  = ev_ext_q ? xa.ch : xl.ch;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) req_q <= '0;
      else     req_q <= req_d;
   end

   // Stage 3: admit whole sequences only. Requests are at least one PS/2 frame
   // apart, so a pending second escape byte never collides with a new request.
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wp_q, rp_q, count;
   logic [CW-1:0] free;
   logic          esc_pend_q, overflow_q;
   logic [7:0]    esc_ch_q, push_byte;
   logic          pop, accept, push;

   assign count     = wp_q - rp_q;
   assign valid     = (count != '0);
   assign pop       = valid & ready;
   assign free      = CW'(FIFO_DEPTH) - CW'(count) + CW'(pop);
   assign accept    = req_q.vld && (free >= (req_q.esc ? CW'(2) : CW'(1)));
   assign push      = esc_pend_q | accept;
   assign push_byte = esc_pend_q ? esc_ch_q : (req_q.esc ? ASC_ESC : req_q.ch);

   always_ff @(posedge clk) begin
      if (clr) begin
         wp_q       <= '0;
         rp_q       <= '0;
         esc_pend_q <= 1'b0;
         esc_ch_q   <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         if (push) wp_q <= wp_q + 1'b1;
         if (pop)  rp_q <= rp_q + 1'b1;
         esc_pend_q <= accept & req_q.esc;
         esc_ch_q   <= req_q.ch;
         overflow_q <= req_q.vld & ~accept;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q[AW-1:0]] <= push_byte;
   end

   assign data      = valid ? mem_q[rp_q[AW-1:0]] : 8'h00;
   assign frame_err = rx_err;
   assign overflow  = overflow_q;

endmodule
